fetch_sequencer: RTL

Instruction-sequencing controller for the vector-encryption core. It owns the program counter, fetches 16-bit instructions from the synchronous instruction memory and presents each one to the instruction decoder. It then samples the decoder's control outputs to choose the next PC (sequential, conditional jump, memory stall or halt). It sits between the instruction ROM and the decoder, and is the only block that advances execution.

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches instructions for the decoder and chooses the next PC from its outputs
module fetch_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_instruction,
    output logic               o_instr_valid,
    input  logic               i_enable_jump,
    input  logic [1:0]         i_jump_cond,
    input  logic [ADDR_W-1:0]  i_jump_address,
    input  logic               i_enable_mem,
    input  logic               i_flag_end,
    input  logic               i_flag_z,
    input  logic               i_flag_gt,
    output logic               o_mem_go,
    input  logic               i_mem_done,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_busy,
    output logic               o_halted,
    output logic [CNT_W-1:0]   o_retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_RESOLVE, S_WAIT_MEM, S_HALT
    } state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_pc, r_imem_addr, w_pc_next;
    logic [INSTR_W-1:0] r_instruction;
    logic [CNT_W-1:0]   r_retired;
    logic               r_mem_go, w_mem_go, w_retire, w_clear, w_taken;

    assign w_taken = i_jump_cond == 2'b00 ? i_flag_z :
                     i_jump_cond == 2'b01 ? i_flag_gt :
                     i_jump_cond == 2'b10 ? 1'b1 : !i_flag_z;

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_mem_go  = 1'b0;
        w_retire  = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (i_start) begin
                    w_next    = S_FETCH;
                    w_pc_next = '0;
                    w_clear   = 1'b1;
                end
            end
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_RESOLVE;
            S_RESOLVE: begin
                // END outranks a memory op, which outranks a jump
                if (i_flag_end) begin
                    w_next   = S_HALT;
                    w_retire = 1'b1;
                end else if (i_enable_mem) begin
                    w_next   = S_WAIT_MEM;
                    w_mem_go = 1'b1;
                end else begin
                    w_next    = S_FETCH;
                    w_retire  = 1'b1;
                    w_pc_next = (i_enable_jump && w_taken) ? i_jump_address : r_pc + ADDR_W'(1);
                end
            end
            S_WAIT_MEM: begin
                if (i_mem_done) begin
                    w_next    = S_FETCH;
                    w_retire  = 1'b1;
                    w_pc_next = r_pc + ADDR_W'(1);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_imem_addr   <= '0;
            r_instruction <= '0;
            r_retired     <= '0;
            r_mem_go      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pc     <= w_pc_next;
            r_mem_go <= w_mem_go;
            if (w_next == S_FETCH)
                r_imem_addr <= w_pc_next;
            if (r_state == S_LATCH)
                r_instruction <= i_imem_data;
            r_retired <= w_clear ? '0 :
                         (w_retire && r_retired != '1) ? r_retired + CNT_W'(1) : r_retired;
        end
    end

    assign o_imem_addr   = r_imem_addr;
    assign o_instruction = r_instruction;
    assign o_instr_valid = r_state == S_DECODE;
    assign o_mem_go      = r_mem_go;
    assign o_pc          = r_pc;
    assign o_busy        = r_state != S_IDLE && r_state != S_HALT;
    assign o_halted      = r_state == S_HALT;
    assign o_retired     = r_retired;
endmodule
